// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: prescaled pixel tick, H/V counters and
// registered x/y, display enable, sync and line/frame strobes aligned one pixel behind.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 1,
  parameter int X_W      = 11,
  parameter int Y_W      = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           resync,
  output logic           pix_ce,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           de,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int P_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [P_W-1:0] P_LAST = P_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
  localparam logic           H_ON   = (H_POL != 0);
  localparam logic           V_ON   = (V_POL != 0);

  logic [P_W-1:0] r_presc;
  logic           r_ce;
  logic [X_W-1:0] r_h;
  logic [Y_W-1:0] r_v;

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_de;
  logic           r_hs;
  logic           r_vs;
  logic           r_ls;
  logic           r_fs;

  logic [P_W-1:0] w_presc_nxt;
  logic [31:0]    w_h32;
  logic [31:0]    w_v32;
  logic           w_de;
  logic           w_hs_on;
  logic           w_vs_on;

  always_comb begin
    w_presc_nxt = (r_presc == P_LAST) ? '0 : r_presc + P_W'(1);
    w_h32       = 32'(r_h);
    w_v32       = 32'(r_v);
    w_de        = (w_h32 < 32'(H_ACTIVE)) && (w_v32 < 32'(V_ACTIVE));
    w_hs_on     = (w_h32 >= 32'(HS_BEG)) && (w_h32 < 32'(HS_END));
    w_vs_on     = (w_v32 >= 32'(VS_BEG)) && (w_v32 < 32'(VS_END));
  end

  // r_ce mirrors (r_presc == P_LAST) but is held low in reset/resync, so even
  // with CLK_DIV=1 the first tick only arrives one clk after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_ce    <= 1'b0;
      r_h     <= '0;
      r_v     <= '0;
    end else if (resync) begin
      r_presc <= '0;
      r_ce    <= 1'b0;
      r_h     <= '0;
      r_v     <= '0;
    end else begin
      r_presc <= w_presc_nxt;
      r_ce    <= (w_presc_nxt == P_LAST);
      if (r_ce) begin
        if (r_h == H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == V_LAST) ? '0 : r_v + Y_W'(1);
        end else begin
          r_h <= r_h + X_W'(1);
        end
      end
    end
  end

  // Output stage: sampled from the pre-increment counters on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_de <= 1'b0;
      r_hs <= ~H_ON;
      r_vs <= ~V_ON;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end else if (resync) begin
      r_x  <= '0;
      r_y  <= '0;
      r_de <= 1'b0;
      r_hs <= ~H_ON;
      r_vs <= ~V_ON;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end else if (r_ce) begin
      r_x  <= r_h;
      r_y  <= r_v;
      r_de <= w_de;
      r_hs <= w_hs_on ? H_ON : ~H_ON;
      r_vs <= w_vs_on ? V_ON : ~V_ON;
      r_ls <= (r_h == '0);
      r_fs <= (r_h == '0) && (r_v == '0);
    end
  end

  assign pix_ce      = r_ce;
  assign x           = r_x;
  assign y           = r_y;
  assign de          = r_de;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule
